// File: rtl/rns_pkg.sv
// Shared types and constants for the RNS (233/239/241/251) to binary reverse converter:
// residue word layout, moduli, MRC step table and FSM state encoding.
package rns_pkg;

   typedef struct packed {
      logic [7:0] r3;
      logic [7:0] r2;
      logic [7:0] r1;
      logic [7:0] r0;
   } rns_t;

   localparam logic [7:0]  M0     = 8'd233;
   localparam logic [7:0]  M1     = 8'd239;
   localparam logic [7:0]  M2     = 8'd241;
   localparam logic [7:0]  M3     = 8'd251;
   localparam logic [32:0] M      = 33'd3368562317;
   localparam logic [31:0] HALF_M = 32'd1684281158;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_MRC    = 2'd1;
   localparam logic [1:0] S_HORNER = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = S_IDLE,
      MRC    = S_MRC,
      HORNER = S_HORNER,
      DONE   = S_DONE
   } state_t;

   typedef struct packed {
      logic [1:0] i;
      logic [1:0] j;
      logic [7:0] m;
      logic [7:0] inv;
   } mrc_step_t;

   // Digit pair, target modulus and INV[i][j] = m_i^-1 mod m_j for each MRC step
   function automatic mrc_step_t mrc_step(input logic [2:0] step);
      mrc_step_t s;
      case (step)
         3'd0:    s = '{i: 2'd0, j: 2'd1, m: M1, inv: 8'd199};
         3'd1:    s = '{i: 2'd0, j: 2'd2, m: M2, inv: 8'd30};
         3'd2:    s = '{i: 2'd0, j: 2'd3, m: M3, inv: 8'd237};
         3'd3:    s = '{i: 2'd1, j: 2'd2, m: M2, inv: 8'd120};
         3'd4:    s = '{i: 2'd1, j: 2'd3, m: M3, inv: 8'd230};
         default: s = '{i: 2'd2, j: 2'd3, m: M3, inv: 8'd25};
      endcase
      return s;
   endfunction

   function automatic logic [7:0] mod_reduce(input logic [7:0] r, input logic [7:0] m);
      return (r >= m) ? (r - m) : r;
   endfunction

endpackage

// File: rtl/rns_modmulsub.sv
// Combinational ((a - b) mod m) * c mod m on 8-bit operands; requires b < m and a < m.
module rns_modmulsub (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] m,
   input  logic [7:0] c,
   output logic [7:0] r
);

   logic [7:0]  diff;
   logic [15:0] prod;

   always_comb begin
      // 8-bit wrap of a-b followed by +m lands exactly on a-b+m, which is < m <= 255
      diff = a - b;
      if (a < b)
         diff = diff + m;
      prod = {8'b0, diff} * {8'b0, c};
      r    = 8'(prod % {8'b0, m});
   end

endmodule

// File: rtl/rns_to_bin.sv
// Sequential mixed-radix reverse converter: one RNS word in, binary value out after 9 clocks.
// Optional macro SIGNED_OUT_EN: y is two's complement centred on zero instead of 0..M-1.
module rns_to_bin
   import rns_pkg::*;
#(
   parameter bit ERR_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] x_rns,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [32:0] y,
   output logic        err,
   output logic        out_valid,
   input  logic        out_ready
);

   state_t     state;
   logic [2:0] cnt;
   logic [7:0] t [4];
   logic [31:0] acc;

   rns_t       x_in;
   logic       in_err;
   mrc_step_t  stp;
   logic [7:0] mrc_a;
   logic [7:0] mrc_b;
   logic [7:0] mrc_res;
   logic [31:0] horner_next;
   logic [32:0] y_conv;

   assign x_in   = x_rns;
   assign in_err = (x_in.r0 >= M0) | (x_in.r1 >= M1) | (x_in.r2 >= M2) | (x_in.r3 >= M3);

   always_comb begin
      stp   = mrc_step(cnt);
      mrc_a = t[stp.j];
      mrc_b = t[stp.i];
   end

   rns_modmulsub u_modmulsub (
      .a (mrc_a),
      .b (mrc_b),
      .m (stp.m),
      .c (stp.inv),
      .r (mrc_res)
   );

   always_comb begin
      horner_next = acc;
      case (cnt[1:0])
         2'd0:    horner_next = {24'b0, t[2]} + 32'd241 * {24'b0, t[3]};
         2'd1:    horner_next = {24'b0, t[1]} + 32'd239 * acc;
         default: horner_next = {24'b0, t[0]} + 32'd233 * acc;
      endcase
   end

`ifdef SIGNED_OUT_EN
   // Signed fold-back shares the last Horner cycle, so latency matches the unsigned build
   assign y_conv = (horner_next > HALF_M) ? ({1'b0, horner_next} - M) : {1'b0, horner_next};
`else
   assign y_conv = {1'b0, horner_next};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         y         <= '0;
         for (int unsigned k = 0; k < 4; k++)
            t[k] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!in_ready) begin
                  in_ready <= 1'b1;
               end else if (in_valid) begin
                  t[0]     <= mod_reduce(x_in.r0, M0);
                  t[1]     <= mod_reduce(x_in.r1, M1);
                  t[2]     <= mod_reduce(x_in.r2, M2);
                  t[3]     <= mod_reduce(x_in.r3, M3);
                  err      <= in_err;
                  in_ready <= 1'b0;
                  cnt      <= '0;
                  state    <= MRC;
               end
            end
            MRC: begin
               t[stp.j] <= mrc_res;
               if (cnt == 3'd5) begin
                  cnt   <= '0;
                  state <= HORNER;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            HORNER: begin
               if (cnt == 3'd2) begin
                  y         <= (ERR_ZERO && err) ? '0 : y_conv;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end else begin
                  acc <= horner_next;
                  cnt <= cnt + 3'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rns_to_bin.sv
// Self-checking bench for rns_to_bin; reference derives residues from a random integer with %.
module tb_rns_to_bin;

   localparam longint unsigned MT   = 64'd3368562317;
   localparam longint unsigned HALF = 64'd1684281158;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] x_rns = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [32:0] y;
   logic        err;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   rns_to_bin #(.ERR_ZERO(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .x_rns     (x_rns),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .err       (err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] to_rns(input longint unsigned x);
      return {8'(x % 251), 8'(x % 241), 8'(x % 239), 8'(x % 233)};
   endfunction

   function automatic logic [32:0] exp_y(input longint unsigned x);
`ifdef SIGNED_OUT_EN
      if (x > HALF)
         return 33'(longint'(x) - longint'(MT));
`endif
      return 33'(x);
   endfunction

   // Handshake one word in and out; returns observed output, clocks from accept to valid.
   task automatic drive_word(input logic [31:0] w, output logic [32:0] yo, output logic eo,
                             output int lat, output bit tmo);
      int n;
      tmo = 1'b0;
      yo  = '0;
      eo  = 1'b0;
      lat = 0;
      n   = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tmo = 1'b1;
         return;
      end
      x_rns    = w;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         tmo = 1'b1;
         return;
      end
      yo        = y;
      eo        = err;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 4;
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got=%b want=0", err); end
      if (y !== 33'd0)        begin failures++; $display("FAIL reset_y got=%0h want=0", y); end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early got=%b want=0", in_ready); end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_directed();
      logic [31:0] w [4];
      longint unsigned xv [4];
      logic [32:0] yo;
      logic eo;
      int lat;
      bit tmo;
      w[0] = 32'h00000000; xv[0] = 0;
      w[1] = 32'h01010101; xv[1] = 1;
      w[2] = 32'hF7242C44; xv[2] = 1000;
      w[3] = 32'hFAF0EEE8; xv[3] = MT - 1;
      for (int i = 0; i < 4; i++) begin
         drive_word(w[i], yo, eo, lat, tmo);
         checks++;
         if (tmo) begin
            failures++;
            $display("FAIL directed_timeout word=%h", w[i]);
         end else begin
            checks += 3;
            if (yo !== exp_y(xv[i])) begin failures++; $display("FAIL directed_y word=%h got=%0h want=%0h", w[i], yo, exp_y(xv[i])); end
            if (eo !== 1'b0)         begin failures++; $display("FAIL directed_err word=%h got=%b want=0", w[i], eo); end
            if (lat != 9)            begin failures++; $display("FAIL directed_latency word=%h got=%0d want=9", w[i], lat); end
         end
      end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL directed_in_ready_after got=%b want=1", in_ready); end
   endtask

   task automatic test_random();
      longint unsigned xv;
      logic [32:0] yo;
      logic eo;
      int lat;
      bit tmo;
      for (int i = 0; i < 24; i++) begin
         if (i == 0)      xv = HALF;
         else if (i == 1) xv = HALF + 1;
         else begin
            do xv = longint'($urandom()); while (xv >= MT);
         end
         drive_word(to_rns(xv), yo, eo, lat, tmo);
         checks++;
         if (tmo) begin
            failures++;
            $display("FAIL random_timeout x=%0d", xv);
         end else if (yo !== exp_y(xv) || eo !== 1'b0) begin
            failures++;
            $display("FAIL random_conv x=%0d got y=%0h err=%b want y=%0h err=0", xv, yo, eo, exp_y(xv));
         end
      end
   endtask

   task automatic test_err();
      logic [7:0] r [4];
      logic [7:0] mods [4];
      logic [32:0] yo;
      logic eo;
      int lat;
      bit tmo;
      int k;
      mods[0] = 8'd233; mods[1] = 8'd239; mods[2] = 8'd241; mods[3] = 8'd251;
      for (int i = 0; i < 9; i++) begin
         if (i == 0) begin
            r[0] = 8'd233; r[1] = 8'd0; r[2] = 8'd0; r[3] = 8'd0;
         end else begin
            for (int q = 0; q < 4; q++) r[q] = 8'($urandom_range(0, int'(mods[q]) - 1));
            k = int'($urandom_range(0, 3));
            r[k] = 8'($urandom_range(int'(mods[k]), 255));
         end
         drive_word({r[3], r[2], r[1], r[0]}, yo, eo, lat, tmo);
         checks++;
         if (tmo) begin
            failures++;
            $display("FAIL err_timeout word=%h", {r[3], r[2], r[1], r[0]});
         end else if (eo !== 1'b1 || yo !== 33'd0) begin
            failures++;
            $display("FAIL err_word word=%h got y=%0h err=%b want y=0 err=1", {r[3], r[2], r[1], r[0]}, yo, eo);
         end
      end
   endtask

   task automatic test_backpressure();
      longint unsigned xv;
      int n;
      do xv = longint'($urandom()); while (xv >= MT);
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      x_rns = to_rns(xv);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!out_valid) begin
         failures++;
         $display("FAIL backpressure_timeout");
         return;
      end
      for (int c = 0; c < 5; c++) begin
         x_rns    = 32'h01010101;
         in_valid = (c % 2 == 0);
         @(negedge clk);
         checks += 4;
         if (out_valid !== 1'b1)   begin failures++; $display("FAIL hold_out_valid cyc=%0d got=%b want=1", c, out_valid); end
         if (y !== exp_y(xv))      begin failures++; $display("FAIL hold_y cyc=%0d got=%0h want=%0h", c, y, exp_y(xv)); end
         if (err !== 1'b0)         begin failures++; $display("FAIL hold_err cyc=%0d got=%b want=0", c, err); end
         if (in_ready !== 1'b0)    begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b want=0", c, in_ready); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
      if (in_ready !== 1'b1)  begin failures++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
      // ignored pulses must not have queued a conversion
      n = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      checks++;
      if (n != 0) begin failures++; $display("FAIL ignored_in_valid_queued got=%0d valid cycles want=0", n); end
   endtask

   task automatic test_back_to_back();
      longint unsigned xv;
      int first, second;
      logic prev;
      xv = 64'd123456789;
      x_rns     = to_rns(xv);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      first  = -1;
      second = -1;
      prev   = out_valid;
      for (int c = 0; c < 60 && second < 0; c++) begin
         @(negedge clk);
         if (out_valid && !prev) begin
            checks++;
            if (y !== exp_y(xv)) begin failures++; $display("FAIL b2b_y got=%0h want=%0h", y, exp_y(xv)); end
            if (first < 0) first = c;
            else second = c;
         end
         prev = out_valid;
      end
      in_valid = 1'b0;
      checks++;
      if (second < 0) begin
         failures++;
         $display("FAIL b2b_timeout first=%0d second=%0d", first, second);
      end else if (second - first != 11) begin
         failures++;
         $display("FAIL b2b_interval got=%0d want=11", second - first);
      end
      repeat (15) @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [32:0] yo;
      logic eo;
      int lat;
      bit tmo;
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      x_rns    = 32'hF7242C44;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL midreset_in_ready got=%b want=0", in_ready); end
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      checks++;
      if (n != 0) begin failures++; $display("FAIL midreset_dropped got=%0d valid cycles want=0", n); end
      drive_word(32'h01010101, yo, eo, lat, tmo);
      checks++;
      if (tmo) begin
         failures++;
         $display("FAIL midreset_timeout");
      end else begin
         checks += 2;
         if (yo !== 33'd1 || eo !== 1'b0) begin failures++; $display("FAIL midreset_next_y got y=%0h err=%b want y=1 err=0", yo, eo); end
         if (lat != 9) begin failures++; $display("FAIL midreset_latency got=%0d want=9", lat); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_err();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
